fifo_write_arbiter: RTL and testbench

- Shares the write port of one FIFO controller among REQ_NUM producers.
- Round-robin grant; a grant is held for a burst of up to BURST_LEN words.
- Forwards the granted producer's valid/data to the FIFO write interface combinationally.
- Backpressures every producer from the FIFO full flag.

---
 rtl/fifo_write_arbiter.sv | 78 +++++++
 tb/tb_fifo_write_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: shares one FIFO write port among REQ_NUM producers with burst-held round-robin grants.
// Define FIFO_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest index wins).
module fifo_write_arbiter #(
  parameter int WIDTH     = 8,
  parameter int REQ_NUM   = 4,
  parameter int REQ_LOG   = 2,
  parameter int BURST_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_NUM-1:0]         req_valid,
  input  logic [REQ_NUM*WIDTH-1:0]   req_data,
  output logic [REQ_NUM-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_write_req,
  output logic [WIDTH-1:0]           fifo_write_data,
  output logic [REQ_LOG-1:0]         grant_id,
  output logic                       busy
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  logic [0:0]         state_q, state_d;
  logic [REQ_LOG-1:0] grant_q, grant_d, pick, idx;
  logic [7:0]         cnt_q, cnt_d;
  logic               burst, xfer, done;
`ifndef FIFO_ARB_FIXED_PRIO_EN
  logic [REQ_LOG-1:0] last_q, last_d;
`endif
  // Scan from the far end so the closest matching index is the final assignment.
  always_comb begin
    pick = '0;
    idx  = '0;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      idx = REQ_LOG'(i);
      if (req_valid[idx]) pick = idx;
    end
`else
    for (int i = REQ_NUM; i >= 1; i--) begin
      idx = REQ_LOG'((int'(last_q) + i) % REQ_NUM);
      if (req_valid[idx]) pick = idx;
    end
`endif
  end
  assign burst           = state_q == BURST;
  assign busy            = burst;
  assign xfer            = burst & req_valid[grant_q] & ~fifo_full;
  assign done            = burst & (~req_valid[grant_q] | (xfer & (cnt_q == 8'(BURST_LEN - 1))));
  assign fifo_write_req  = xfer;
  assign req_ready       = (burst & ~fifo_full) ? REQ_NUM'(1) << grant_q : '0;
  assign fifo_write_data = req_data[grant_q*WIDTH +: WIDTH];
  assign grant_id        = grant_q;
  always_comb begin
    state_d = burst ? (done ? IDLE : BURST) : (|req_valid ? BURST : IDLE);
    grant_d = (~burst & |req_valid) ? pick : grant_q;
    cnt_d   = ~burst ? 8'd0 : xfer ? cnt_q + 8'd1 : cnt_q;
`ifndef FIFO_ARB_FIXED_PRIO_EN
    last_d  = done ? grant_q : last_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
      last_q  <= REQ_LOG'(REQ_NUM - 1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
`ifndef FIFO_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed checks of grant order, burst framing, backpressure and reset.
module tb_fifo_write_arbiter;
  localparam int W = 8, N = 4, L = 2;
  logic clk = 0, rst = 1, fifo_full = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W-1:0] req_data = '0;
  logic fifo_write_req, busy;
  logic [W-1:0] fifo_write_data;
  logic [L-1:0] grant_id;
  int checks = 0, errors = 0;
  int rem[N], seq[N];
  logic [N-1:0] acc, s_ready;
  logic [31:0] pat, bpat;
  logic [7:0] wq[$];
  int gq[$];
  logic bprev, s_busy, s_wr;
  logic [L-1:0] s_grant;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.WIDTH(W), .REQ_NUM(N), .REQ_LOG(L), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_write_req(fifo_write_req), .fifo_write_data(fifo_write_data),
    .grant_id(grant_id), .busy(busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = rem[i] != 0;
      req_data[i*W +: W] = W'(i * 16 + seq[i]);
    end
  endtask

  // Sample at negedge, advance the producer model just after the rising edge.
  task automatic step();
    @(negedge clk);
    s_busy = busy; s_wr = fifo_write_req; s_ready = req_ready; s_grant = grant_id;
    acc = req_ready & req_valid;
    pat = {pat[30:0], fifo_write_req};
    bpat = {bpat[30:0], busy};
    if (fifo_write_req) wq.push_back(fifo_write_data);
    if (busy && !bprev) gq.push_back(int'(grant_id));
    bprev = busy;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) begin rem[i]--; seq[i]++; end
    drive();
  endtask

  task automatic reset_dut();
    rst = 1; fifo_full = 0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; end
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    pat = 0; bpat = 0; bprev = 0;
    wq.delete(); gq.delete();
  endtask

  task automatic check_words(input string tag, input logic [7:0] exp[$]);
    check({tag, "_count"}, 32'(wq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check(tag, (i < wq.size()) ? 32'(wq[i]) : 'x, 32'(exp[i]));
  endtask

  task automatic check_grants(input string tag, input int exp[$]);
    check({tag, "_count"}, 32'(gq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check(tag, (i < gq.size()) ? 32'(gq[i]) : 'x, 32'(exp[i]));
  endtask

  initial begin
    // Reset state, even with every producer requesting
    rst = 1; req_valid = '1;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_wr", 32'(fifo_write_req), 0);
    check("rst_ready", 32'(req_ready), 0);

`ifdef FIFO_ARB_FIXED_PRIO_EN
    reset_dut();
    for (int i = 0; i < N; i++) rem[i] = 1000;
    drive();
    repeat (15) step();
    check_grants("fp_grants", '{0, 0, 0});
    check("fp_pat", pat[14:0], 15'b0_1111_0_1111_0_1111);
`else
    // Producers 0 and 2, six words each
    reset_dut();
    rem[0] = 6; rem[2] = 6;
    drive();
    repeat (19) step();
    check("rr_pat", pat[18:0], 19'b0_1111_0_1111_0_11_0_0_11_0_0);
    check_grants("rr_grants", '{0, 2, 0, 2});
    check_words("rr_data", '{8'h00, 8'h01, 8'h02, 8'h03, 8'h20, 8'h21, 8'h22, 8'h23,
                             8'h04, 8'h05, 8'h24, 8'h25});

    // Producer 1 yields after two words; producer 3 is next
    reset_dut();
    rem[1] = 2; rem[3] = 4;
    drive();
    repeat (5) step();
    check("yield_busy", bpat[4:0], 5'b01110);
    check("yield_wr", pat[4:0], 5'b01100);
    repeat (5) step();
    check_grants("yield_grants", '{1, 3});
    check_words("yield_data", '{8'h10, 8'h11, 8'h30, 8'h31, 8'h32, 8'h33});
`endif

    // Single producer 3 streaming continuously
    reset_dut();
    rem[3] = 1000;
    drive();
    repeat (15) step();
    check("single_wr", pat[14:0], 15'b0_1111_0_1111_0_1111);
    check("single_busy", bpat[14:0], 15'b0_1111_0_1111_0_1111);
    check("single_grant", 32'(s_grant), 3);
    check_grants("single_grants", '{3, 3, 3});

    // Three cycles of fifo_full in mid-burst
    reset_dut();
    rem[1] = 4;
    drive();
    repeat (3) step();
    fifo_full = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("full_ready", 32'(s_ready), 0);
      check("full_wr", 32'(s_wr), 0);
      check("full_busy", 32'(s_busy), 1);
      check("full_grant", 32'(s_grant), 1);
    end
    fifo_full = 0;
    repeat (3) step();
    check("full_pat", pat[8:0], 9'b011000110);
    check_words("full_data", '{8'h10, 8'h11, 8'h12, 8'h13});

    // Reset in mid-burst
    reset_dut();
    rem[2] = 100;
    drive();
    repeat (3) step();
    check("mid_busy_pre", 32'(s_busy), 1);
    rst = 1;
    step();
    rst = 0;
    step();
    check("mid_busy", 32'(s_busy), 0);
    check("mid_grant", 32'(s_grant), 0);
    check("mid_wr", 32'(s_wr), 0);
    check("mid_ready", 32'(s_ready), 0);
    step();
    check("mid_regrant", 32'(s_grant), 2);
    check("mid_rebusy", 32'(s_busy), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
